// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl: round-robin arbiter and sequencer that shares one
// combinational ALU between two requesters.
//
// Handshake rule for every channel in this block: a transfer happens on a
// rising clk edge where valid and ready are both 1. A producer holds valid
// and its payload steady until that edge; ready carries no obligation.
module alu_share_ctrl #(
    parameter int XLEN   = 32,
    parameter int CTRL_W = 4,
    parameter int OP_MAX = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              r0_valid,
    output logic              r0_ready,
    input  logic [CTRL_W-1:0] r0_ctrl,
    input  logic [XLEN-1:0]   r0_x,
    input  logic [XLEN-1:0]   r0_y,
    output logic              r0_rsp_valid,
    input  logic              r0_rsp_ready,
    output logic [XLEN-1:0]   r0_rsp_data,
    output logic              r0_rsp_err,
    input  logic              r1_valid,
    output logic              r1_ready,
    input  logic [CTRL_W-1:0] r1_ctrl,
    input  logic [XLEN-1:0]   r1_x,
    input  logic [XLEN-1:0]   r1_y,
    output logic              r1_rsp_valid,
    input  logic              r1_rsp_ready,
    output logic [XLEN-1:0]   r1_rsp_data,
    output logic              r1_rsp_err,
    output logic [CTRL_W-1:0] alu_ctrl,
    output logic [XLEN-1:0]   alu_x,
    output logic [XLEN-1:0]   alu_y,
    input  logic [XLEN-1:0]   alu_out,
    output logic              busy
);

    localparam int SHW = $clog2(XLEN);
    localparam logic [CTRL_W-1:0] OP_SLL  = CTRL_W'(2);
    localparam logic [CTRL_W-1:0] OP_SRL  = CTRL_W'(6);
    localparam logic [CTRL_W-1:0] OP_SRA  = CTRL_W'(7);
    localparam logic [CTRL_W-1:0] OP_LAST = CTRL_W'(OP_MAX);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;
    logic              rr;          // requester that wins the next tie
    logic              owner;       // requester owning the operation in flight
    logic [XLEN-1:0]   result;
    logic              err;

    logic              grant;
    logic              accept;
    logic [CTRL_W-1:0] sel_ctrl;
    logic [XLEN-1:0]   sel_x;
    logic [XLEN-1:0]   sel_y;
    logic              sel_illegal;
    logic              sel_shift;
    logic              owner_rsp_ready;

    // Grant selection and the operand mux feeding the latch.
    always_comb begin
        grant = 1'b0;
        if (r0_valid && r1_valid) begin
            grant = rr;
        end else if (r1_valid) begin
            grant = 1'b1;
        end
        accept      = (state == IDLE) && (r0_valid || r1_valid);
        sel_ctrl    = grant ? r1_ctrl : r0_ctrl;
        sel_x       = grant ? r1_x    : r0_x;
        sel_y       = grant ? r1_y    : r0_y;
        sel_illegal = sel_ctrl > OP_LAST;
        sel_shift   = (sel_ctrl == OP_SLL) || (sel_ctrl == OP_SRL) || (sel_ctrl == OP_SRA);
        owner_rsp_ready = owner ? r1_rsp_ready : r0_rsp_ready;
    end

    // Next-state logic; illegal ops skip the ALU and go straight to RESP.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = sel_illegal ? RESP : EXEC;
                end
            end
            EXEC: state_next = RESP;
            RESP: begin
                if (owner_rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State, round-robin pointer, operation and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            rr       <= 1'b0;
            owner    <= 1'b0;
            result   <= '0;
            err      <= 1'b0;
            alu_ctrl <= '0;
            alu_x    <= '0;
            alu_y    <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                owner <= grant;
                rr    <= ~grant;
                if (sel_illegal) begin
                    result <= '0;
                    err    <= 1'b1;
                end else begin
                    alu_ctrl <= sel_ctrl;
                    alu_x    <= sel_x;
                    // Only the low log2(XLEN) bits are a meaningful shift amount.
                    alu_y    <= sel_shift ? XLEN'(sel_y[SHW-1:0]) : sel_y;
                end
            end
            if (state == EXEC) begin
                result <= alu_out;
                err    <= 1'b0;
            end
        end
    end

    // Response channels: only the owner sees the result, and only in RESP.
    always_comb begin
        r0_ready     = accept && !grant;
        r1_ready     = accept && grant;
        r0_rsp_valid = (state == RESP) && !owner;
        r1_rsp_valid = (state == RESP) && owner;
        r0_rsp_data  = r0_rsp_valid ? result : '0;
        r1_rsp_data  = r1_rsp_valid ? result : '0;
        r0_rsp_err   = r0_rsp_valid && err;
        r1_rsp_err   = r1_rsp_valid && err;
        busy         = state != IDLE;
    end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// tb_alu_share_ctrl: self-checking bench for alu_share_ctrl with a
// behavioural ALU attached and a reference model of the expected results.
module tb_alu_share_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        r0_valid, r0_ready, r0_rsp_valid, r0_rsp_ready, r0_rsp_err;
    logic [3:0]  r0_ctrl;
    logic [31:0] r0_x, r0_y, r0_rsp_data;
    logic        r1_valid, r1_ready, r1_rsp_valid, r1_rsp_ready, r1_rsp_err;
    logic [3:0]  r1_ctrl;
    logic [31:0] r1_x, r1_y, r1_rsp_data;
    logic [3:0]  alu_ctrl;
    logic [31:0] alu_x, alu_y, alu_out;
    logic        busy;

    int n_cmp = 0;
    int n_fail = 0;
    logic [32:0] exp_q[$];

    alu_share_ctrl dut (
        .clk(clk), .rst(rst),
        .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_ctrl(r0_ctrl), .r0_x(r0_x), .r0_y(r0_y),
        .r0_rsp_valid(r0_rsp_valid), .r0_rsp_ready(r0_rsp_ready), .r0_rsp_data(r0_rsp_data),
        .r0_rsp_err(r0_rsp_err),
        .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_ctrl(r1_ctrl), .r1_x(r1_x), .r1_y(r1_y),
        .r1_rsp_valid(r1_rsp_valid), .r1_rsp_ready(r1_rsp_ready), .r1_rsp_data(r1_rsp_data),
        .r1_rsp_err(r1_rsp_err),
        .alu_ctrl(alu_ctrl), .alu_x(alu_x), .alu_y(alu_y), .alu_out(alu_out), .busy(busy)
    );

    // Clock.
    always #5 clk = ~clk;

    // Behavioural ALU; shifts use the whole y so unsanitised amounts show up.
    always_comb begin
        case (alu_ctrl)
            4'd0: alu_out = alu_x + alu_y;
            4'd1: alu_out = alu_x - alu_y;
            4'd2: alu_out = alu_x << alu_y;
            4'd3: alu_out = {31'd0, $signed(alu_x) < $signed(alu_y)};
            4'd4: alu_out = {31'd0, alu_x < alu_y};
            4'd5: alu_out = alu_x ^ alu_y;
            4'd6: alu_out = alu_x >> alu_y;
            4'd7: alu_out = $signed(alu_x) >>> alu_y;
            4'd8: alu_out = alu_x | alu_y;
            4'd9: alu_out = alu_x & alu_y;
            default: alu_out = 32'hDEADBEEF;
        endcase
    end

    // Reference model: returns {err, data} for one operation.
    function automatic logic [32:0] ref_op(input logic [3:0] c, input logic [31:0] x,
                                           input logic [31:0] y);
        int unsigned sh;
        longint sx, sy;
        sh = int'(y % 32);
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        case (int'(c))
            0: return {1'b0, 32'(x + y)};
            1: return {1'b0, 32'(x - y)};
            2: return {1'b0, 32'(x * (33'd1 << sh))};
            3: return {1'b0, (sx < sy) ? 32'd1 : 32'd0};
            4: return {1'b0, ({1'b0, x} < {1'b0, y}) ? 32'd1 : 32'd0};
            5: return {1'b0, x ^ y};
            6: return {1'b0, x / (33'd1 << sh)};
            7: return {1'b0, 32'(sx >>> sh)};
            8: return {1'b0, x | y};
            9: return {1'b0, x & y};
            default: return {1'b1, 32'd0};
        endcase
    endfunction

    // Driver: idle all requester inputs.
    task automatic drive_idle();
        r0_valid = 0; r0_ctrl = 0; r0_x = 0; r0_y = 0; r0_rsp_ready = 0;
        r1_valid = 0; r1_ctrl = 0; r1_x = 0; r1_y = 0; r1_rsp_ready = 0;
    endtask

    // Driver: synchronous reset pulse, returns at a negedge with rst low.
    task automatic do_reset();
        @(negedge clk);
        drive_idle();
        rst = 1;
        @(posedge clk);
        @(negedge clk);
        rst = 0;
    endtask

    task automatic set_req(input int req, input logic v, input logic [3:0] c,
                           input logic [31:0] x, input logic [31:0] y);
        if (req == 0) begin r0_valid = v; r0_ctrl = c; r0_x = x; r0_y = y; end
        else begin r1_valid = v; r1_ctrl = c; r1_x = x; r1_y = y; end
    endtask

    // Driver: wait (bounded) for requester req's rsp_valid, starting at a negedge.
    task automatic wait_rsp(input int req, output int lat, output bit ok);
        ok = 0;
        lat = 1;
        for (int i = 0; i < 20 && !ok; i++) begin
            if ((req == 0) ? r0_rsp_valid : r1_rsp_valid) ok = 1;
            else begin @(negedge clk); lat++; end
        end
    endtask

    // Driver: consume the pending response of requester req.
    task automatic consume(input int req);
        if (req == 0) r0_rsp_ready = 1; else r1_rsp_ready = 1;
        @(posedge clk);
        @(negedge clk);
        r0_rsp_ready = 0;
        r1_rsp_ready = 0;
    endtask

    // Driver: full operation on one requester; starts and ends at a negedge.
    task automatic run_op(input int req, input logic [3:0] c, input logic [31:0] x,
                          input logic [31:0] y, output logic [31:0] d, output logic e,
                          output int lat, output bit ok);
        d = '0; e = 0; lat = 0; ok = 0;
        set_req(req, 1, c, x, y);
        for (int i = 0; i < 20 && !ok; i++) begin
            #1;
            if ((req == 0) ? r0_ready : r1_ready) ok = 1;
            else @(negedge clk);
        end
        if (!ok) begin set_req(req, 0, 0, 0, 0); return; end
        @(posedge clk);
        @(negedge clk);
        set_req(req, 0, 0, 0, 0);
        wait_rsp(req, lat, ok);
        if (!ok) return;
        d = (req == 0) ? r0_rsp_data : r1_rsp_data;
        e = (req == 0) ? r0_rsp_err : r1_rsp_err;
        consume(req);
    endtask

    task automatic test_reset();
        logic [3:0] c;
        @(negedge clk);
        drive_idle();
        rst = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        c = 4'b0;
        n_cmp++;
        if ({r0_ready, r1_ready, r0_rsp_valid, r1_rsp_valid, r0_rsp_err, r1_rsp_err, busy} !== 7'd0) begin
            n_fail++;
            $display("FAIL reset_flags got=%b want=0", {r0_ready, r1_ready, r0_rsp_valid, r1_rsp_valid, r0_rsp_err, r1_rsp_err, busy});
        end
        n_cmp++;
        if ({r0_rsp_data, r1_rsp_data} !== 64'd0) begin
            n_fail++; $display("FAIL reset_data got=%h %h want=0", r0_rsp_data, r1_rsp_data);
        end
        n_cmp++;
        if ({alu_ctrl, alu_x, alu_y} !== {c, 64'd0}) begin
            n_fail++; $display("FAIL reset_alu got=%h %h %h want=0", alu_ctrl, alu_x, alu_y);
        end
        rst = 0;
    endtask

    task automatic test_basic_add();
        int lat;
        bit ok;
        do_reset();
        set_req(0, 1, 4'd0, 32'hFFFFFFFF, 32'd2);
        #1;
        n_cmp++;
        if (r0_ready !== 1'b1 || r1_ready !== 1'b0) begin
            n_fail++; $display("FAIL add_ready got=%b%b want=10", r0_ready, r1_ready);
        end
        @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (r0_ready !== 1'b0 || busy !== 1'b1) begin
            n_fail++; $display("FAIL add_ready_pulse got ready=%b busy=%b want ready=0 busy=1", r0_ready, busy);
        end
        set_req(0, 0, 0, 0, 0);
        wait_rsp(0, lat, ok);
        n_cmp++;
        if (!ok || lat != 2) begin
            n_fail++; $display("FAIL add_latency got ok=%0d lat=%0d want lat=2", ok, lat);
        end
        n_cmp++;
        if (r0_rsp_data !== 32'h00000001 || r0_rsp_err !== 1'b0 || r1_rsp_valid !== 1'b0) begin
            n_fail++; $display("FAIL add_result got=%h err=%b r1v=%b want=00000001 err=0 r1v=0", r0_rsp_data, r0_rsp_err, r1_rsp_valid);
        end
        consume(0);
        n_cmp++;
        if (busy !== 1'b0 || r0_rsp_valid !== 1'b0) begin
            n_fail++; $display("FAIL add_done got busy=%b rv=%b want 0 0", busy, r0_rsp_valid);
        end
    endtask

    task automatic test_round_robin();
        int who, lat;
        bit ok;
        logic [32:0] exp;
        do_reset();
        set_req(0, 1, 4'd0, 32'd3, 32'd4);
        set_req(1, 1, 4'd1, 32'd5, 32'd7);
        for (int g = 0; g < 4; g++) begin
            who = -1;
            for (int i = 0; i < 20 && who < 0; i++) begin
                #1;
                if (r0_ready && r1_ready) who = 2;
                else if (r0_ready) who = 0;
                else if (r1_ready) who = 1;
                else @(negedge clk);
            end
            n_cmp++;
            if (who != g % 2) begin
                n_fail++; $display("FAIL rr_grant%0d got=%0d want=%0d", g, who, g % 2);
            end
            if (who < 0 || who > 1) break;
            @(posedge clk);
            @(negedge clk);
            wait_rsp(who, lat, ok);
            exp = (who == 0) ? ref_op(4'd0, 32'd3, 32'd4) : ref_op(4'd1, 32'd5, 32'd7);
            n_cmp++;
            if (!ok || ((who == 0) ? r0_rsp_data : r1_rsp_data) !== exp[31:0]
                || ((who == 0) ? r1_rsp_valid : r0_rsp_valid) !== 1'b0) begin
                n_fail++;
                $display("FAIL rr_data%0d got=%h want=%h ok=%0d", g, (who == 0) ? r0_rsp_data : r1_rsp_data, exp[31:0], ok);
            end
            consume(who);
        end
        set_req(0, 0, 0, 0, 0);
        set_req(1, 0, 0, 0, 0);
    endtask

    task automatic test_ops();
        logic [31:0] d;
        logic e;
        int lat;
        bit ok;
        logic [3:0]  dc[4] = '{4'd2, 4'd7, 4'd3, 4'd4};
        logic [31:0] dx[4] = '{32'd1, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF};
        logic [31:0] dy[4] = '{32'h21, 32'd31, 32'd0, 32'd0};
        logic [31:0] dw[4] = '{32'd2, 32'hFFFFFFFF, 32'd1, 32'd0};
        for (int i = 0; i < 4; i++) begin
            run_op(1, dc[i], dx[i], dy[i], d, e, lat, ok);
            n_cmp++;
            if (!ok || d !== dw[i] || e !== 1'b0 || lat != 2) begin
                n_fail++; $display("FAIL dir_op%0d got=%h err=%b lat=%0d want=%h", i, d, e, lat, dw[i]);
            end
        end
        for (int i = 0; i < 40; i++) begin
            logic [3:0] c;
            logic [31:0] x, y;
            logic [32:0] exp;
            int req;
            req = int'($urandom_range(0, 1));
            c = 4'($urandom_range(0, 11));
            x = $urandom;
            y = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 70)) : $urandom;
            exp_q.push_back(ref_op(c, x, y));
            run_op(req, c, x, y, d, e, lat, ok);
            exp = exp_q.pop_front();
            n_cmp++;
            if (!ok || {e, d} !== exp || lat != (exp[32] ? 1 : 2)) begin
                n_fail++;
                $display("FAIL rand_op%0d req=%0d c=%0d x=%h y=%h got=%b_%h lat=%0d want=%b_%h", i, req, c, x, y, e, d, lat, exp[32], exp[31:0]);
            end
        end
    endtask

    task automatic test_illegal();
        logic [31:0] d;
        logic e;
        int lat;
        bit ok;
        run_op(0, 4'd8, 32'h0F0F0000, 32'h000000F0, d, e, lat, ok);
        n_cmp++;
        if (!ok || d !== 32'h0F0F00F0) begin
            n_fail++; $display("FAIL ill_prior got=%h want=0f0f00f0", d);
        end
        run_op(0, 4'hC, 32'h12345678, 32'h9ABCDEF0, d, e, lat, ok);
        n_cmp++;
        if (!ok || d !== 32'd0 || e !== 1'b1 || lat != 1) begin
            n_fail++; $display("FAIL ill_rsp got=%h err=%b lat=%0d want=0 err=1 lat=1", d, e, lat);
        end
        n_cmp++;
        if (alu_ctrl !== 4'd8 || alu_x !== 32'h0F0F0000 || alu_y !== 32'h000000F0) begin
            n_fail++; $display("FAIL ill_alu_hold got=%h %h %h want=8 0f0f0000 000000f0", alu_ctrl, alu_x, alu_y);
        end
    endtask

    task automatic test_backpressure();
        int lat;
        bit ok;
        logic [32:0] exp;
        do_reset();
        set_req(0, 1, 4'd5, 32'hA5A5A5A5, 32'h0000FFFF);
        @(posedge clk);
        @(negedge clk);
        set_req(0, 0, 0, 0, 0);
        set_req(1, 1, 4'd9, 32'hF0F0F0F0, 32'h3C3C3C3C);
        wait_rsp(0, lat, ok);
        exp = ref_op(4'd5, 32'hA5A5A5A5, 32'h0000FFFF);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_cmp++;
            if (!ok || r0_rsp_valid !== 1'b1 || r0_rsp_data !== exp[31:0] || busy !== 1'b1
                || r1_ready !== 1'b0 || r1_rsp_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold%0d got v=%b d=%h busy=%b r1rdy=%b want v=1 d=%h busy=1 r1rdy=0", i, r0_rsp_valid, r0_rsp_data, busy, r1_ready, exp[31:0]);
            end
        end
        consume(0);
        #1;
        n_cmp++;
        if (r1_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL bp_release got r1rdy=%b busy=%b want 1 0", r1_ready, busy);
        end
        @(posedge clk);
        @(negedge clk);
        set_req(1, 0, 0, 0, 0);
        wait_rsp(1, lat, ok);
        n_cmp++;
        if (!ok || r1_rsp_data !== 32'h30303030) begin
            n_fail++; $display("FAIL bp_r1 got=%h want=30303030", r1_rsp_data);
        end
        consume(1);
    endtask

    task automatic test_reset_mid();
        bit seen;
        int who;
        do_reset();
        set_req(0, 1, 4'd0, 32'd10, 32'd20);
        @(posedge clk);
        @(negedge clk);
        set_req(0, 0, 0, 0, 0);
        rst = 1;
        @(posedge clk);
        @(negedge clk);
        rst = 0;
        n_cmp++;
        if ({r0_ready, r1_ready, r0_rsp_valid, r1_rsp_valid, r0_rsp_err, r1_rsp_err, busy} !== 7'd0
            || {r0_rsp_data, r1_rsp_data, alu_x, alu_y} !== 128'd0 || alu_ctrl !== 4'd0) begin
            n_fail++; $display("FAIL mid_reset_outputs got busy=%b rv=%b%b alu=%h %h %h want all 0", busy, r0_rsp_valid, r1_rsp_valid, alu_ctrl, alu_x, alu_y);
        end
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (r0_rsp_valid || r1_rsp_valid || busy) seen = 1;
        end
        n_cmp++;
        if (seen !== 1'b0) begin
            n_fail++; $display("FAIL mid_reset_no_rsp got activity=%b want 0", seen);
        end
        set_req(0, 1, 4'd0, 32'd1, 32'd1);
        set_req(1, 1, 4'd0, 32'd2, 32'd2);
        #1;
        who = r0_ready ? 0 : (r1_ready ? 1 : -1);
        n_cmp++;
        if (who != 0) begin
            n_fail++; $display("FAIL mid_reset_rr got=%0d want=0", who);
        end
        @(negedge clk);
        drive_idle();
        do_reset();
    endtask

    initial begin
        rst = 1;
        drive_idle();
        test_reset();
        test_basic_add();
        test_round_robin();
        test_ops();
        test_illegal();
        test_backpressure();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/alu_share_ctrl.md
Name: alu_share_ctrl

Overview:
- Two-requester arbiter and sequencer for the core's single combinational ALU (4-bit op code, 32-bit operands).
- Accepts one operation at a time via valid/ready and grants round-robin.
- Drives the ALU from registered operands, captures the result, and returns it on the owning requester's response channel.
- Sanitises shift amounts and rejects undefined op codes so the ALU never evaluates an unspecified case.

Parameters:
- XLEN, 32, operand/result width.
- CTRL_W, 4, op-code width.
- OP_MAX, 9, highest legal op code (0=ADD 1=SUB 2=SLL 3=SLT 4=SLTU 5=XOR 6=SRL 7=SRA 8=OR 9=AND).

Ports:
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- r0_valid  in  1  requester 0 operation valid.
- r0_ready  out  1  requester 0 operation accepted this cycle.
- r0_ctrl  in  CTRL_W  requester 0 op code.
- r0_x / r0_y  in  XLEN each  requester 0 operands.
- r0_rsp_valid  out  1  result for requester 0 available.
- r0_rsp_ready  in  1  requester 0 consumes result.
- r0_rsp_data  out  XLEN  result.
- r0_rsp_err  out  1  illegal op code flag.
- r1_*  same set for requester 1.
- alu_ctrl  out  CTRL_W  to ALU.
- alu_x / alu_y  out  XLEN each  to ALU.
- alu_out  in  XLEN  from ALU.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (rst=1 at posedge): state=IDLE; rr pointer=0; all op/result registers=0; all outputs 0 (ready, rsp_valid, rsp_err, rsp_data, alu_ctrl/x/y, busy). Reset mid-operation abandons any pending op or result; no response is produced.
- States:
  - IDLE: grant computed combinationally. Only r1 valid -> r1; only r0 valid -> r0; both valid -> requester at rr pointer. rX_ready=1 only for the granted requester, only in IDLE. On accept: latch owner, ctrl, x, y; rr pointer <= other requester.
    - Legal op -> EXEC.
    - ctrl > OP_MAX -> RESP with data=0, err=1; ALU registers not updated.
  - EXEC (1 cycle): ALU driven from op registers; at posedge result reg <= alu_out, err=0 -> RESP.
  - RESP: owner's rsp_valid=1 with rsp_data/rsp_err stable until the owner's rsp_ready=1 at posedge -> IDLE. The non-owner's rsp_valid stays 0.
- Latency: accept at edge N -> rsp_valid visible after edge N+1 (illegal op: after edge N, no EXEC). Earliest next accept is the cycle after the response handshake. Minimum 3 cycles per legal op.
- No new accept outside IDLE, even if the other requester is valid. That requester's valid/operands must stay held (standard valid/ready: valid must not drop before ready).
- Shift sanitising at latch time: for ctrl ∈ {2,6,7}, alu_y = {0, y[4:0]}, i.e. only the low log2(XLEN) bits are kept. All other ops pass y unmodified.
- Arithmetic: ADD/SUB wrap modulo 2^XLEN. SLT/SLTU give 0 or 1 zero-extended. SRA is arithmetic on x.
- alu_ctrl/x/y hold their last latched values outside EXEC; they are only meaningful in EXEC.
- Round-robin fairness: under continuous contention, grants strictly alternate r0, r1, r0, …
- rsp_ready asserted while rsp_valid=0 is ignored.

Test Plan:
- Reset, then r0 ADD x=0xFFFFFFFF y=2 -> r0_ready pulses 1 cycle; r0_rsp_valid one edge later, data=0x00000001, err=0.
- r0 and r1 valid together from reset, both hold valid -> grants r0 then r1 then r0 (rr alternates). r1 SUB 5-7 -> 0xFFFFFFFE.
- r1 SLL x=1 y=0x00000021 -> data=0x00000002 (shamt 1). SRA x=0x80000000 y=31 -> 0xFFFFFFFF. SLT x=-1 y=0 -> 1; SLTU same -> 0.
- r0 ctrl=0xC -> rsp after 1 edge, data=0, err=1; alu_ctrl/x/y unchanged from prior op.
- Backpressure: hold r0_rsp_ready=0 for 5 cycles -> rsp_valid/data stable, busy=1, r1 valid not accepted; release -> IDLE, r1 accepted next cycle.
- rst asserted in EXEC -> next cycle all outputs 0, state IDLE, no response ever issued for that op; pointer back to r0.
